bitwise_operand_skid_stage: RTL and testbench

- Registered valid/ready operand stage directly upstream of the bit-wise logic units (NAND, AND, OR, ...).
- Accepts operand pairs {a, b} from a streaming producer and presents them, registered, to the combinational bit-wise unit.
- Decouples producer and consumer with a 2-entry skid buffer so full throughput is kept while ready is fully registered.
- Keeps a wrapping count of operand pairs delivered downstream.

---
 rtl/bitwise_operand_skid_stage_pkg.sv | 13 +
 rtl/bitwise_operand_skid_stage_counter.sv | 27 ++
 rtl/bitwise_operand_skid_stage.sv | 165 ++++++++++++++++
 tb/tb_bitwise_operand_skid_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bitwise_operand_skid_stage_pkg.sv
// Shared types and defaults for the bit-wise operand pipeline.
// State encoding of the operand skid stage and the default operand width.
package bitwise_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/bitwise_operand_skid_stage_counter.sv
// Enable-increment wrapping counter with asynchronous active-low reset.
// Used to count delivered transfers; wraps silently at 2^CW.
module bitwise_xfer_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_r;

  // Counter register: step by one on each enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/bitwise_operand_skid_stage.sv
// Registered valid/ready operand stage feeding the bit-wise logic units.
// Two-entry skid buffer keeps full throughput with a flop-driven s_ready.
module bitwise_operand_skid_stage
  import bitwise_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_a,
  input  logic [N-1:0]  s_b,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [N-1:0]  m_a,
  output logic [N-1:0]  m_b,
  output logic [CW-1:0] xfer_count
);

  skid_state_t  state_r;
  skid_state_t  next_state_s;
  logic         s_ready_r;
  logic         m_valid_r;
  logic         s_ready_nxt_s;
  logic         m_valid_nxt_s;
  logic         s_xfer_s;
  logic         m_xfer_s;
  logic         load_main_s;
  logic         load_skid_s;
  logic         skid_to_main_s;
  logic [N-1:0] main_a_r;
  logic [N-1:0] main_b_r;
  logic [N-1:0] skid_a_r;
  logic [N-1:0] skid_b_r;

  assign s_xfer_s = s_valid & s_ready_r;
  assign m_xfer_s = m_valid_r & m_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; any unused encoding falls back to EMPTY.
  always_comb begin
    next_state_s = EMPTY;
    case (state_r)
      EMPTY: begin
        if (s_xfer_s) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = EMPTY;
        end
      end
      BUSY: begin
        if (s_xfer_s && !m_xfer_s) begin
          next_state_s = FULL;
        end else if (!s_xfer_s && m_xfer_s) begin
          next_state_s = EMPTY;
        end else begin
          next_state_s = BUSY;
        end
      end
      FULL: begin
        if (m_xfer_s) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = FULL;
        end
      end
      default: begin
        next_state_s = EMPTY;
      end
    endcase
  end

  // Output decode: handshake flags for the coming state and datapath load strobes.
  always_comb begin
    s_ready_nxt_s  = (next_state_s != FULL);
    m_valid_nxt_s  = (next_state_s != EMPTY);
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    case (state_r)
      EMPTY: begin
        load_main_s = s_xfer_s;
      end
      BUSY: begin
        if (s_xfer_s && m_xfer_s) begin
          load_main_s = 1'b1;
        end else if (s_xfer_s) begin
          load_skid_s = 1'b1;
        end else begin
          load_main_s = 1'b0;
        end
      end
      FULL: begin
        skid_to_main_s = m_xfer_s;
      end
      default: begin
        load_main_s = 1'b0;
      end
    endcase
  end

  // Handshake flags are registered so neither depends combinationally on m_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
    end else begin
      s_ready_r <= s_ready_nxt_s;
      m_valid_r <= m_valid_nxt_s;
    end
  end

  // Main and skid operand registers; main holds value whenever no load is strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_a_r <= '0;
      main_b_r <= '0;
      skid_a_r <= '0;
      skid_b_r <= '0;
    end else begin
      if (load_main_s) begin
        main_a_r <= s_a;
        main_b_r <= s_b;
      end else if (skid_to_main_s) begin
        main_a_r <= skid_a_r;
        main_b_r <= skid_b_r;
      end else begin
        main_a_r <= main_a_r;
        main_b_r <= main_b_r;
      end
      if (load_skid_s) begin
        skid_a_r <= s_a;
        skid_b_r <= s_b;
      end else begin
        skid_a_r <= skid_a_r;
        skid_b_r <= skid_b_r;
      end
    end
  end

  bitwise_xfer_counter #(
    .CW (CW)
  ) u_xfer_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (m_xfer_s),
    .count (xfer_count)
  );

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_a     = main_a_r;
  assign m_b     = main_b_r;

endmodule

// File: tb/tb_bitwise_operand_skid_stage.sv
// Scoreboard bench for the operand skid stage: a FIFO model of at most two
// buffered pairs predicts handshakes, data order and the delivered count.
module tb_bitwise_operand_skid_stage;

  localparam int N   = 8;
  localparam int CW  = 16;
  localparam int CWW = 4;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pair_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           m_ready = 1'b0;
  logic [N-1:0]   s_a = '0;
  logic [N-1:0]   s_b = '0;
  logic           s_ready, m_valid, s_ready_w, m_valid_w;
  logic [N-1:0]   m_a, m_b, m_a_w, m_b_w;
  logic [CW-1:0]  xfer_count;
  logic [CWW-1:0] xfer_count_w;

  pair_t       exp_q[$];
  int unsigned n_del = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  bitwise_operand_skid_stage #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .m_valid(m_valid), .m_ready(m_ready),
    .m_a(m_a), .m_b(m_b), .xfer_count(xfer_count)
  );

  bitwise_operand_skid_stage #(.N(N), .CW(CWW)) dut_w (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w),
    .s_a(s_a), .s_b(s_b), .m_valid(m_valid_w), .m_ready(m_ready),
    .m_a(m_a_w), .m_b(m_b_w), .xfer_count(xfer_count_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model, then advances the model.
  always @(negedge clk) begin
    int  occ;
    logic acc, dlv;
    if (!rst_n) begin
      exp_q.delete();
      n_del = 0;
      chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_m_a", {24'd0, m_a}, 32'd0);
      chk("rst_m_b", {24'd0, m_b}, 32'd0);
      chk("rst_count", {16'd0, xfer_count}, 32'd0);
      chk("rst_count_w", {28'd0, xfer_count_w}, 32'd0);
    end else begin
      occ = exp_q.size();
      chk("m_valid", {31'd0, m_valid}, {31'd0, occ > 0});
      chk("s_ready", {31'd0, s_ready}, {31'd0, occ < 2});
      chk("m_valid_w", {31'd0, m_valid_w}, {31'd0, occ > 0});
      chk("s_ready_w", {31'd0, s_ready_w}, {31'd0, occ < 2});
      chk("xfer_count", {16'd0, xfer_count}, n_del % 32'd65536);
      chk("xfer_count_w", {28'd0, xfer_count_w}, n_del % 32'd16);
      if (occ > 0) begin
        chk("m_a", {24'd0, m_a}, {24'd0, exp_q[0].a});
        chk("m_b", {24'd0, m_b}, {24'd0, exp_q[0].b});
        chk("m_a_w", {24'd0, m_a_w}, {24'd0, exp_q[0].a});
        chk("m_b_w", {24'd0, m_b_w}, {24'd0, exp_q[0].b});
      end
      dlv = m_ready && (occ > 0);
      acc = s_valid && (occ < 2);
      if (dlv) begin
        void'(exp_q.pop_front());
        n_del++;
      end
      if (acc) begin
        exp_q.push_back('{a: s_a, b: s_b});
      end
    end
  end

  task automatic cyc(input logic sv, input logic [N-1:0] a, input logic [N-1:0] b, input logic mr);
    s_valid = sv;
    s_a     = a;
    s_b     = b;
    m_ready = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    // Reset held for three cycles, then idle.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 8'h00, 8'h00, 1'b1);
    chk("idle_m_a", {24'd0, m_a}, 32'd0);
    chk("idle_m_b", {24'd0, m_b}, 32'd0);

    // Single pair.
    cyc(1'b1, 8'hA5, 8'h0F, 1'b1);
    chk("single_m_valid", {31'd0, m_valid}, 32'd1);
    chk("single_m_a", {24'd0, m_a}, 32'h000000A5);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    chk("single_done", {31'd0, m_valid}, 32'd0);
    chk("single_count", {16'd0, xfer_count}, 32'd1);

    // Streaming 16 back-to-back pairs.
    for (int i = 0; i < 16; i++) begin
      ra = 8'(i);
      cyc(1'b1, ra, ~ra, 1'b1);
    end
    repeat (2) cyc(1'b0, 8'h00, 8'h00, 1'b1);
    chk("stream_count", {16'd0, xfer_count}, 32'd17);
    chk("wrap_count_w", {28'd0, xfer_count_w}, 32'd1);

    // Backpressure fills the skid; a third offer is refused.
    cyc(1'b1, 8'h11, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 8'h44, 1'b0);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    chk("full_m_a", {24'd0, m_a}, 32'h00000011);
    cyc(1'b1, 8'h55, 8'h66, 1'b0);
    chk("full_hold_m_a", {24'd0, m_a}, 32'h00000011);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    chk("drain1_m_a", {24'd0, m_a}, 32'h00000033);
    chk("drain1_s_ready", {31'd0, s_ready}, 32'd1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    chk("drain2_m_valid", {31'd0, m_valid}, 32'd0);

    // Asynchronous reset while FULL.
    cyc(1'b1, 8'h77, 8'h88, 1'b0);
    cyc(1'b1, 8'h99, 8'hAA, 1'b0);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_m_valid", {31'd0, m_valid}, 32'd0);
    chk("async_s_ready", {31'd0, s_ready}, 32'd1);
    chk("async_m_a", {24'd0, m_a}, 32'd0);
    chk("async_count", {16'd0, xfer_count}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 8'h00, 8'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 2) != 0));
    end
    repeat (4) cyc(1'b0, 8'h00, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
